// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller.
// Build option: define CPU_RUN_FLAGS_EN to store zf/of alongside each trace entry.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } run_state_t;

  // Width of one trace FIFO entry for a given ALU result width.
  function automatic int unsigned entry_width(input int unsigned data_w);
`ifdef CPU_RUN_FLAGS_EN
    return data_w + 2;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/cpu_trace_fifo.sv
// First-word-fall-through trace FIFO with synchronous clear.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cpu_trace_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop at full frees the slot the simultaneous push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; clear overrides any concurrent push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents are only observable through non-empty reads.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer and trace capture for the single-cycle R-type CPU.
// Holds the core in reset for RST_CYCLES, enables it for RUN_CYCLES and
// records each cycle's ALU result into a trace FIFO.
// Build option: CPU_RUN_FLAGS_EN stores zf/of per entry; otherwise rd_zf/rd_of read 0.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned RUN_CYCLES = 35
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [DATA_W-1:0]                 alu_f,
  input  logic                              zf,
  input  logic                              of,
  output logic                              cpu_rst,
  output logic                              cpu_en,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(RUN_CYCLES+1)-1:0]   cyc_cnt,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_zf,
  output logic                              rd_of,
  output logic                              ovf
);

  localparam int unsigned CW = $clog2(RUN_CYCLES + 1);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned EW = entry_width(DATA_W);

  localparam logic [CW-1:0] LAST_RUN = CW'(RUN_CYCLES - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  run_state_t    state;
  logic [RW-1:0] rst_cnt;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_clear;
  logic          push;
  logic          pop;
  logic          drop;
  logic          start_ok;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  // An abort in the same cycle suppresses both the start and the capture.
  assign start_ok   = start & ~abort & ((state == S_IDLE) | (state == S_DONE));
  assign fifo_clear = start_ok;
  assign push       = cpu_en & ~abort;
  assign pop        = rd_ready & ~fifo_empty;
  assign drop       = push & fifo_full & ~pop;
  assign rd_valid   = ~fifo_empty;

`ifdef CPU_RUN_FLAGS_EN
  assign wr_entry = {of, zf, alu_f};
  assign rd_data  = rd_entry[DATA_W-1:0];
  assign rd_zf    = rd_entry[DATA_W];
  assign rd_of    = rd_entry[DATA_W+1];
`else
  logic unused_flags;
  assign unused_flags = zf ^ of;
  assign wr_entry     = alu_f;
  assign rd_data      = rd_entry;
  assign rd_zf        = 1'b0;
  assign rd_of        = 1'b0;
`endif

  cpu_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (fifo_clear),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Run sequencer with registered control outputs and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cpu_rst <= 1'b1;
      cpu_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cyc_cnt <= '0;
      rst_cnt <= '0;
      ovf     <= 1'b0;
    end else if (abort) begin
      state   <= S_IDLE;
      cpu_rst <= 1'b1;
      cpu_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (drop) ovf <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RESET;
            cpu_rst <= 1'b1;
            cpu_en  <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            cyc_cnt <= '0;
            ovf     <= 1'b0;
            rst_cnt <= RST_LOAD;
          end
        end
        S_RESET: begin
          if (rst_cnt == '0) begin
            state   <= S_RUN;
            cpu_rst <= 1'b0;
            cpu_en  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        S_RUN: begin
          cyc_cnt <= cyc_cnt + CW'(1);
          if (cyc_cnt == LAST_RUN) begin
            state  <= S_DONE;
            cpu_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (DEPTH=4, RST_CYCLES=2, RUN_CYCLES=6).
module tb_cpu_run_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 4;
  localparam int unsigned RSC = 2;
  localparam int unsigned RNC = 6;
`ifdef CPU_RUN_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] alu_f = '0;
  logic          zf = 1'b0;
  logic          of = 1'b0;
  logic          rd_ready = 1'b0;
  logic          cpu_rst, cpu_en, busy, done, rd_valid, rd_zf, rd_of, ovf;
  logic [2:0]    cyc_cnt;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] vals [6] = '{32'h0000_0001, 32'hDEAD_0002, 32'h0000_0003,
                              32'h0000_0000, 32'hA5A5_5A5A, 32'hFFFF_FFFF};
  logic          zfs  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic          ofs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_ctrl #(
    .DATA_W     (DW),
    .DEPTH      (DEP),
    .RST_CYCLES (RSC),
    .RUN_CYCLES (RNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .alu_f    (alu_f),
    .zf       (zf),
    .of       (of),
    .cpu_rst  (cpu_rst),
    .cpu_en   (cpu_en),
    .busy     (busy),
    .done     (done),
    .cyc_cnt  (cyc_cnt),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_zf    (rd_zf),
    .rd_of    (rd_of),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check the head entry against vals[idx], then pop it.
  task automatic pop_check(input string tag, input int idx);
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, rd_data, vals[idx]);
    check({tag, "_zf"}, 32'(rd_zf), 32'(FLAGS & zfs[idx]));
    check({tag, "_of"}, 32'(rd_of), 32'(FLAGS & ofs[idx]));
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  // Start a run, count RESET cycles, then feed vals[] on each enabled cycle.
  task automatic run_once(input int abort_at, input int pop_from, output int rc, output int ec);
    int i;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_empty", 32'(rd_valid), 32'd0);
    check("start_ovf", 32'(ovf), 32'd0);
    check("start_cyc", 32'(cyc_cnt), 32'd0);
    rc = 0;
    while (!cpu_en && rc < 20) begin
      @(negedge clk);
      rc++;
    end
    i = 0;
    while (cpu_en && i < 12) begin
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        break;
      end
      alu_f    = vals[i % 6];
      zf       = zfs[i % 6];
      of       = ofs[i % 6];
      rd_ready = (i >= pop_from);
      if (i >= pop_from) check("sim_head", rd_data, vals[i - 4]);
      @(negedge clk);
      i++;
    end
    rd_ready = 1'b0;
    alu_f    = '0;
    zf       = 1'b0;
    of       = 1'b0;
    ec       = i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, ec;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset release.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_cpu_en", 32'(cpu_en), 32'd0);
      check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_cyc", 32'(cyc_cnt), 32'd0);
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_ovf", 32'(ovf), 32'd0);
    check("idle_data", rd_data, 32'd0);

    // Full run without pops: first four kept, overflow flagged.
    run_once(99, 99, rc, ec);
    check("t1_rst_cycles", 32'(rc), 32'd2);
    check("t1_en_cycles", 32'(ec), 32'd6);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_cpu_rst", 32'(cpu_rst), 32'd0);
    check("t1_cyc", 32'(cyc_cnt), 32'd6);
    check("t1_ovf", 32'(ovf), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_valid_hold", 32'(rd_valid), 32'd1);
    pop_check("t1_pop0", 0);
    pop_check("t1_pop1", 1);

    // Restart from DONE; full FIFO with simultaneous push/pop on last two captures.
    run_once(99, 4, rc, ec);
    check("t2_en_cycles", 32'(ec), 32'd6);
    check("t2_done", 32'(done), 32'd1);
    check("t2_ovf", 32'(ovf), 32'd0);
    pop_check("t2_pop2", 2);
    pop_check("t2_pop3", 3);
    pop_check("t2_pop4", 4);
    pop_check("t2_pop5", 5);
    check("t2_empty", 32'(rd_valid), 32'd0);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check("t2_pop_empty_valid", 32'(rd_valid), 32'd0);
    check("t2_pop_empty_data", rd_data, 32'd0);

    // Abort after three captures.
    run_once(3, 99, rc, ec);
    check("t3_captures", 32'(ec), 32'd3);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    check("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t3_cpu_en", 32'(cpu_en), 32'd0);
    check("t3_cyc", 32'(cyc_cnt), 32'd3);
    pop_check("t3_pop0", 0);
    pop_check("t3_pop1", 1);
    // Start together with abort: abort wins, entry survives.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("t3_sa_busy", 32'(busy), 32'd0);
    check("t3_sa_valid", 32'(rd_valid), 32'd1);
    check("t3_sa_data", rd_data, vals[2]);
    // A real start clears the leftover entry.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_clr_valid", 32'(rd_valid), 32'd0);
    check("t3_clr_busy", 32'(busy), 32'd1);

    // Async reset mid-RUN, between edges.
    rc = 0;
    while (!cpu_en && rc < 20) begin
      @(negedge clk);
      rc++;
    end
    check("t4_reached_run", 32'(cpu_en), 32'd1);
    repeat (2) @(negedge clk);
    check("t4_pre_valid", 32'(rd_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_cpu_en", 32'(cpu_en), 32'd0);
    check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t4_valid", 32'(rd_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cyc", 32'(cyc_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_post_en", 32'(cpu_en), 32'd0);
    check("t4_post_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
